// File: rtl/msrv32_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: instruction fetch and data port share one bus.
// Data wins by default; a small guard forces a fetch after two data grants in a row.
module msrv32_ahb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic        i_gnt_out,
  output logic        i_rvalid_out,
  output logic        i_err_out,
  output logic [31:0] i_rdata_out,
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_wmask_in,
  output logic        d_gnt_out,
  output logic        d_rvalid_out,
  output logic        d_err_out,
  output logic [31:0] d_rdata_out,
  output logic [31:0] haddr_out,
  output logic [31:0] hwdata_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [3:0]  hwmask_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in,
  output logic        timeout_out
);

  typedef enum logic {IDLE, DATA} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic        owner_d, owner_d_nx;
  logic        wr, wr_nx;
  logic [31:0] wdata, wdata_nx;
  logic [7:0]  wait_cnt, wait_nx;
  logic [1:0]  guard, guard_nx;

  logic busy, complete, abort, can_issue, issue, pick_i;
  logic        rsp_err;
  logic [31:0] rsp_data;

  assign busy      = (state == DATA);
  assign complete  = busy && hready_in;
  assign abort     = busy && !hready_in && (wait_cnt == TO_LAST);
  // An error completion never overlaps a new address phase.
  assign can_issue = !busy || (hready_in && !hresp_in);
  assign issue     = rst_in && can_issue && (i_req_in || d_req_in);
  assign pick_i    = i_req_in && (!d_req_in || (guard == 2'd2));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      wr       <= 1'b0;
      wdata    <= '0;
      wait_cnt <= '0;
      guard    <= '0;
    end else begin
      state    <= state_nx;
      owner_d  <= owner_d_nx;
      wr       <= wr_nx;
      wdata    <= wdata_nx;
      wait_cnt <= wait_nx;
      guard    <= guard_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    owner_d_nx = owner_d;
    wr_nx      = wr;
    wdata_nx   = wdata;
    wait_nx    = wait_cnt;
    guard_nx   = guard;
    if (abort) begin
      state_nx = IDLE;
      wait_nx  = '0;
    end else if (issue) begin
      state_nx   = DATA;
      owner_d_nx = !pick_i;
      wr_nx      = !pick_i && d_we_in;
      wdata_nx   = (!pick_i && d_we_in) ? d_wdata_in : '0;
      wait_nx    = '0;
      if (pick_i)
        guard_nx = '0;
      else
        guard_nx = i_req_in ? guard + 2'd1 : '0;
    end else if (complete) begin
      state_nx = IDLE;
      wait_nx  = '0;
    end else if (busy) begin
      wait_nx = wait_cnt + 8'd1;
    end
  end

  always_comb begin
    htrans_out   = 2'b00;
    haddr_out    = '0;
    hwrite_out   = 1'b0;
    hwmask_out   = '0;
    hwdata_out   = '0;
    i_gnt_out    = 1'b0;
    d_gnt_out    = 1'b0;
    i_rvalid_out = 1'b0;
    i_err_out    = 1'b0;
    i_rdata_out  = '0;
    d_rvalid_out = 1'b0;
    d_err_out    = 1'b0;
    d_rdata_out  = '0;
    timeout_out  = abort;
    rsp_err      = abort || hresp_in;
    rsp_data     = (complete && !wr) ? hrdata_in : '0;
    if (issue) begin
      htrans_out = 2'b10;
      haddr_out  = pick_i ? i_addr_in : d_addr_in;
      hwrite_out = !pick_i && d_we_in;
      hwmask_out = pick_i ? 4'hF : d_wmask_in;
      i_gnt_out  = pick_i;
      d_gnt_out  = !pick_i;
    end
    if (busy && wr)
      hwdata_out = wdata;
    if (complete || abort) begin
      if (owner_d) begin
        d_rvalid_out = 1'b1;
        d_err_out    = rsp_err;
        d_rdata_out  = rsp_data;
      end else begin
        i_rvalid_out = 1'b1;
        i_err_out    = rsp_err;
        i_rdata_out  = rsp_data;
      end
    end
  end

endmodule
